// File: rtl/conv_counter.sv
// Conversion counter for the voltmeter back end.
// Fixed mode counts a programmed interval; measure mode counts until the
// synchronised comparator stop arrives, saturating with an overflow flag.
module conv_counter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic             stop_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   stop_s;
  logic                   mode_q;
  logic [WIDTH-1:0]       target_q;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       result_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   ovf_q;

  assign stop_s = sync_q[SYNC_STAGES-1];

  // Stop synchroniser: shifts the comparator level in every cycle, in any state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= stop_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Conversion FSM with registered status, count and result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      target_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= RUN;
            mode_q   <= mode_i;
            target_q <= target_i;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!mode_q && (count_q == target_q)) begin
            result_q <= count_q;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (mode_q && stop_s) begin
            result_q <= count_q;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else if (mode_q && (count_q == '1)) begin
            // Saturate instead of wrapping; a stop on this cycle is handled above.
            ovf_q    <= 1'b1;
            result_q <= '1;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count_o  = count_q;
  assign result_o = result_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_conv_counter.sv
// Self-checking bench for conv_counter: a 16-bit and a 4-bit instance,
// each conversion predicted in closed form from its start edge.
module tb_conv_counter;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start16, mode16, stop16, abort16;
  logic [15:0] tgt16, count16, result16;
  logic        busy16, done16, ovf16;

  logic        start4, mode4, stop4, abort4;
  logic [3:0]  tgt4, count4, result4;
  logic        busy4, done4, ovf4;

  conv_counter #(.WIDTH(16), .SYNC_STAGES(SS)) u16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .mode_i(mode16),
    .target_i(tgt16), .stop_i(stop16), .abort_i(abort16),
    .count_o(count16), .result_o(result16), .busy_o(busy16),
    .done_o(done16), .ovf_o(ovf16)
  );

  conv_counter #(.WIDTH(4), .SYNC_STAGES(SS)) u4 (
    .clk_i(clk), .rst_i(rst), .start_i(start4), .mode_i(mode4),
    .target_i(tgt4), .stop_i(stop4), .abort_i(abort4),
    .count_o(count4), .result_o(result4), .busy_o(busy4),
    .done_o(done4), .ovf_o(ovf4)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_res16 = 0;
  int m_res4  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use4, input logic st, input logic md, input logic sp,
                       input logic ab, input logic [15:0] tg);
    if (use4) begin
      start4 = st; mode4 = md; stop4 = sp; abort4 = ab; tgt4 = tg[3:0];
    end else begin
      start16 = st; mode16 = md; stop16 = sp; abort16 = ab; tgt16 = tg;
    end
  endtask

  task automatic observe(input bit use4, output logic [31:0] cnt, output logic [31:0] res,
                         output logic bsy, output logic dn, output logic ov);
    if (use4) begin
      cnt = {28'd0, count4}; res = {28'd0, result4}; bsy = busy4; dn = done4; ov = ovf4;
    end else begin
      cnt = {16'd0, count16}; res = {16'd0, result16}; bsy = busy16; dn = done16; ov = ovf16;
    end
  endtask

  // One conversion. sa: first start-relative edge at which stop_i is sampled
  // high (<=0 means already high well before start); ab: edge at which abort_i
  // is sampled high (-1 none). Must be called at a negedge with the DUT idle.
  task automatic run_conv(input bit use4, input bit md, input int tgt, input int sa_in,
                          input int ab, input string name);
    int maxv, t, e, res, f, prev, sa, es;
    bit ovx, abd, sp;
    logic [31:0] o_cnt, o_res;
    logic o_bsy, o_dn, o_ov;
    maxv = use4 ? 15 : 65535;
    t    = tgt & maxv;
    prev = use4 ? m_res4 : m_res16;
    sa   = (sa_in <= 0) ? -3 : sa_in;
    if (!md) begin
      e = t + 1; res = t; ovx = 1'b0;
    end else begin
      es = (sa + SS > 1) ? sa + SS : 1;
      if (es <= maxv + 1) begin
        e = es; res = es - 1; ovx = 1'b0;
      end else begin
        e = maxv + 1; res = maxv; ovx = 1'b1;
      end
    end
    abd = (ab >= 1) && (ab <= e);
    f   = abd ? ab : e;
    sp  = 1'b0;
    if (sa <= 0) begin
      drive(use4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      repeat (3) @(negedge clk);
    end
    for (int k = 0; k <= f + 2; k++) begin
      sp = (k >= sa);
      if (k == 0) drive(use4, 1'b1, md, sp, 1'b0, 16'(tgt));
      else        drive(use4, 1'b0, 1'($urandom_range(0, 1)), sp, (k == ab), 16'($urandom));
      @(posedge clk);
      @(negedge clk);
      observe(use4, o_cnt, o_res, o_bsy, o_dn, o_ov);
      chk($sformatf("%s.busy@%0d", name, k), 32'(o_bsy), 32'(k < f));
      chk($sformatf("%s.done@%0d", name, k), 32'(o_dn), 32'(!abd && k == e));
      chk($sformatf("%s.count@%0d", name, k), o_cnt, 32'((k < f) ? k : f - 1));
      chk($sformatf("%s.result@%0d", name, k), o_res, 32'((!abd && k >= e) ? res : prev));
      chk($sformatf("%s.ovf@%0d", name, k), 32'(o_ov), 32'((!abd && k >= e) ? ovx : 1'b0));
    end
    if (!abd) begin
      if (use4) m_res4 = res; else m_res16 = res;
    end
    drive(use4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    repeat (SS + 1) @(negedge clk);
  endtask

  initial begin
    logic [31:0] o_cnt, o_res;
    logic o_bsy, o_dn, o_ov;
    int b2b_busy, b2b_done, sa, ab, tg;
    bit u;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    // Reset held while every input toggles.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        observe(d[0], o_cnt, o_res, o_bsy, o_dn, o_ov);
        chk($sformatf("rst.count%0d", d), o_cnt, 32'd0);
        chk($sformatf("rst.result%0d", d), o_res, 32'd0);
        chk($sformatf("rst.busy%0d", d), 32'(o_bsy), 32'd0);
        chk($sformatf("rst.done%0d", d), 32'(o_dn), 32'd0);
        chk($sformatf("rst.ovf%0d", d), 32'(o_ov), 32'd0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    repeat (SS + 1) @(negedge clk);
    chk("idle.busy16", 32'(busy16), 32'd0);
    chk("idle.busy4", 32'(busy4), 32'd0);

    // Directed scenarios.
    run_conv(1'b0, 1'b0, 10, 1000, -1, "fixed10");
    run_conv(1'b0, 1'b1, 0, 20, -1, "meas20");
    run_conv(1'b1, 1'b1, 0, 1000, -1, "ovf4");
    run_conv(1'b1, 1'b0, 7, 1000, -1, "ovfclr4");
    run_conv(1'b0, 1'b0, 100, 1000, 38, "abort37");
    run_conv(1'b0, 1'b0, 0, 1000, -1, "tgt0");
    run_conv(1'b0, 1'b1, 0, -3, -1, "stopearly");
    run_conv(1'b1, 1'b1, 0, 14, -1, "stopovf_tie4");
    run_conv(1'b1, 1'b1, 0, 15, -1, "stop_late4");
    run_conv(1'b0, 1'b0, 5, 1000, 6, "abort_at_end");
    run_conv(1'b1, 1'b0, 15, 1000, -1, "fixedmax4");

    // start_i held high: RUN(4) DONE IDLE RUN(4) DONE ...
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      b2b_busy = ((k % 6) < 4) ? 1 : 0;
      b2b_done = ((k % 6) == 4) ? 1 : 0;
      chk($sformatf("b2b.busy@%0d", k), 32'(busy16), 32'(b2b_busy));
      chk($sformatf("b2b.done@%0d", k), 32'(done16), 32'(b2b_done));
      chk($sformatf("b2b.count@%0d", k), 32'(count16), 32'(((k % 6) < 4) ? (k % 6) : 3));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    m_res16 = 3;
    repeat (SS + 1) @(negedge clk);
    chk("b2b.result", 32'(result16), 32'd3);

    // Randomised conversions on both widths.
    for (int n = 0; n < 40; n++) begin
      u  = 1'($urandom_range(0, 1));
      tg = int'($urandom_range(0, 40));
      sa = ($urandom_range(0, 7) == 0) ? -3 : int'($urandom_range(1, u ? 25 : 40));
      if (u && $urandom_range(0, 5) == 0) sa = 1000;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45)) : -1;
      run_conv(u, 1'($urandom_range(0, 1)), tg, sa, ab, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a conversion.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd50);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50);
    repeat (10) @(negedge clk);
    chk("midrst.pre_busy", 32'(busy16), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy", 32'(busy16), 32'd0);
    chk("midrst.count", 32'(count16), 32'd0);
    chk("midrst.result16", 32'(result16), 32'd0);
    chk("midrst.result4", 32'(result4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_res16 = 0;
    m_res4  = 0;
    repeat (SS + 1) @(negedge clk);
    run_conv(1'b0, 1'b0, 4, 1000, -1, "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
